// File: rtl/cpu_insencode.sv
`default_nettype none
// ============================================================================
// Module      : cpu_insencode
// Description : Encodes RISC-V instruction fields into a 32-bit instruction
//               word, flags immediate range/alignment errors, and delivers the
//               result through a 2-entry valid/ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_insencode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      fmt,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err,
    output logic [7:0]      err_count
);

    localparam logic [2:0]  c_FMT_R     = 3'd0;
    localparam logic [2:0]  c_FMT_I     = 3'd1;
    localparam logic [2:0]  c_FMT_SHIFT = 3'd2;
    localparam logic [2:0]  c_FMT_S     = 3'd3;
    localparam logic [2:0]  c_FMT_B     = 3'd4;
    localparam logic [2:0]  c_FMT_U     = 3'd5;
    localparam logic [2:0]  c_FMT_J     = 3'd6;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    localparam int          c_SHAMT_W   = (XLEN == 64) ? 6 : 5;
    localparam logic [1:0]  c_DEPTH     = 2'd2;

    logic [31:0] w_shift_instr;
    logic [31:0] w_instr;
    logic        w_err;
    logic        w_sext12_ok;
    logic        w_sext13_ok;
    logic        w_sext21_ok;
    logic        w_sext32_ok;
    logic        w_push;
    logic        w_pop;

    logic [31:0] r_mem_instr [0:1];
    logic        r_mem_err   [0:1];
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;
    logic [7:0]  r_err_count;

    // Sign-extension checks: every bit from the top of the field upward must match.
    assign w_sext12_ok = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
    assign w_sext13_ok = (&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12]);
    assign w_sext21_ok = (&imm[XLEN-1:20]) | ~(|imm[XLEN-1:20]);
    assign w_sext32_ok = (&imm[XLEN-1:31]) | ~(|imm[XLEN-1:31]);

    generate
        if (XLEN == 64) begin : g_shift64
            assign w_shift_instr = {funct7[6:1], imm[5:0], rs1, funct3, rd, opcode};
        end else begin : g_shift32
            assign w_shift_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end
    endgenerate

    always_comb begin
        w_instr = c_NOP;
        w_err   = 1'b0;
        case (fmt)
            c_FMT_R: begin
                w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            c_FMT_I: begin
                w_instr = {imm[11:0], rs1, funct3, rd, opcode};
                w_err   = ~w_sext12_ok;
            end
            c_FMT_SHIFT: begin
                w_instr = w_shift_instr;
                w_err   = |imm[XLEN-1:c_SHAMT_W];
            end
            c_FMT_S: begin
                w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_err   = ~w_sext12_ok;
            end
            c_FMT_B: begin
                w_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], opcode};
                w_err   = ~w_sext13_ok | imm[0];
            end
            c_FMT_U: begin
                w_instr = {imm[31:12], rd, opcode};
                w_err   = (|imm[11:0]) | ~w_sext32_ok;
            end
            c_FMT_J: begin
                w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_err   = ~w_sext21_ok | imm[0];
            end
            default: begin
                w_instr = c_NOP;
                w_err   = 1'b1;
            end
        endcase
    end

    assign in_ready  = (r_count < c_DEPTH);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem_instr[i] <= 32'h0;
                r_mem_err[i]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_instr[r_tail] <= w_instr;
                r_mem_err[r_tail]   <= w_err;
                r_tail              <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'h00;
        end else if (w_push && w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    // Head entry is read straight from storage; stale when empty by design.
    assign out_instr = r_mem_instr[r_head];
    assign out_err   = r_mem_err[r_head];
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_insencode.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_insencode
// Description : Self-checking bench for cpu_insencode with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_insencode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } ent_t;

    ent_t mq[$];
    int   model_errc = 0;

    cpu_insencode #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding and error rules expressed with plain arithmetic on integers.
    function automatic ent_t model_enc(input logic [2:0] f, input logic [6:0] op,
                                       input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] im);
        ent_t r;
        int unsigned u, o, rdv, a, b, c3, c7, base;
        longint s;
        u = im; o = op; rdv = d; a = s1; b = s2; c3 = f3; c7 = f7;
        s = longint'($signed(im));
        base = o + (c3 << 12) + (a << 15);
        r.err = 1'b0;
        case (f)
            3'd0: r.instr = base + (rdv << 7) + (b << 20) + (c7 << 25);
            3'd1: begin
                r.instr = base + (rdv << 7) + ((u % 4096) << 20);
                r.err   = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                r.instr = base + (rdv << 7) + ((u % 32) << 20) + (c7 << 25);
                r.err   = (u > 31);
            end
            3'd3: begin
                r.instr = base + ((u % 32) << 7) + (b << 20) + (((u / 32) % 128) << 25);
                r.err   = (s < -2048) || (s > 2047);
            end
            3'd4: begin
                r.instr = base + (b << 20) + (((u / 2048) % 2) << 7) + (((u / 2) % 16) << 8)
                        + (((u / 32) % 64) << 25) + (((u / 4096) % 2) << 31);
                r.err   = (s < -4096) || (s > 4095) || (u % 2 == 1);
            end
            3'd5: begin
                r.instr = o + (rdv << 7) + (u - (u % 4096));
                r.err   = (u % 4096) != 0;
            end
            3'd6: begin
                r.instr = o + (rdv << 7) + (((u / 4096) % 256) << 12) + (((u / 2048) % 2) << 20)
                        + (((u / 2) % 1024) << 21) + (((u / 1048576) % 2) << 31);
                r.err   = (s < -1048576) || (s > 1048575) || (u % 2 == 1);
            end
            default: begin
                r.instr = 32'h0000_0013;
                r.err   = 1'b1;
            end
        endcase
        return r;
    endfunction

    // Compare against the model, then advance it to what the next edge will do.
    always @(negedge clk) begin
        if (rst_n) begin
            bit do_push, do_pop;
            check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                check("out_instr", out_instr, mq[0].instr);
                check("out_err", {31'd0, out_err}, {31'd0, mq[0].err});
            end
            check("err_count", {24'd0, err_count}, model_errc);
            do_push = in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                ent_t e;
                e = model_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                mq.push_back(e);
                if (e.err && model_errc < 255) model_errc++;
            end
        end
    end

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
        funct7 = 7'd0;
    endtask

    task automatic rand_fields();
        logic [31:0] bnd [16];
        bnd = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576,
                32'd31, 32'd32, 32'h12345000, 32'h12345001, 32'd0};
        fmt = 3'($urandom_range(0, 7));
        opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
            1: imm = bnd[$urandom_range(0, 15)];
            2: imm = $urandom & 32'hFFFF_F000;
            default: imm = $urandom;
        endcase
    endtask

    // Offer the current fields until accepted, bounded.
    task automatic offer();
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL offer_timeout: got no accept, expected accept within 50 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        check("model_pin_I", model_enc(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF).instr, 32'hFFF00093);
        check("model_pin_B", model_enc(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16).instr, 32'h00208863);

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Basic encodings
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF); offer();
        @(negedge clk); check("enc_I", out_instr, 32'hFFF00093); check("enc_I_err", {31'd0, out_err}, 32'd0);
        step();
        set_fields(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000); offer();
        @(negedge clk); check("enc_U", out_instr, 32'h123452B7); check("enc_U_err", {31'd0, out_err}, 32'd0);
        step();
        set_fields(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8); offer();
        @(negedge clk); check("enc_J", out_instr, 32'h008000EF); check("enc_J_err", {31'd0, out_err}, 32'd0);
        step();
        set_fields(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd16); offer();
        @(negedge clk); check("enc_B", out_instr, 32'h00208863); check("enc_B_err", {31'd0, out_err}, 32'd0);
        step();

        // Errors step err_count 1,2,3
        set_fields(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3); offer();
        @(negedge clk); check("err_B_flag", {31'd0, out_err}, 32'd1); check("err_cnt1", {24'd0, err_count}, 32'd1);
        step();
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048); offer();
        @(negedge clk); check("err_I_flag", {31'd0, out_err}, 32'd1); check("err_cnt2", {24'd0, err_count}, 32'd2);
        step();
        set_fields(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'd0); offer();
        @(negedge clk); check("err_nop", out_instr, 32'h00000013); check("err_7_flag", {31'd0, out_err}, 32'd1);
        check("err_cnt3", {24'd0, err_count}, 32'd3);
        step();

        // Backpressure: two accepts fill the buffer, head holds
        out_ready = 1'b0;
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF); offer();
        set_fields(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000); offer();
        set_fields(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_head_stable", out_instr, 32'hFFF00093);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        check("bp_second_head", out_instr, 32'h123452B7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_third_head", out_instr, 32'h008000EF);
        step(); step();

        // Simultaneous push/pop at count 1
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            rand_fields();
            in_valid = 1'b1;
            @(negedge clk);
            check("pp_in_ready", {31'd0, in_ready}, 32'd1);
            if (k > 0) check("pp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        step(); step();

        // Reset with two buffered erroneous entries
        out_ready = 1'b0;
        set_fields(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0); offer(); offer();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        mq.delete();
        model_errc = 0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(); step();

        // Saturation
        set_fields(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b1;
        for (int k = 0; k < 305; k++) step();
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_err_count", {24'd0, err_count}, 32'hFF);
        step();

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            rand_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
